// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
//   Bundles every signal the fetch stage exchanges with the rest of the core:
//   the decode-side handshake (valid/allowin, branch redirect, payload bus)
//   and the synchronous instruction SRAM port.
//
//   Signals
//     br_taken        decode -> IF   one-cycle redirect pulse
//     br_target       decode -> IF   redirect PC, valid with br_taken
//     ds_allowin      decode -> IF   decode can accept an instruction
//     fs_to_ds_valid  IF -> decode   fs_to_ds_bus carries a valid instruction
//     fs_to_ds_bus    IF -> decode   {adef, pc[31:0], inst[31:0]}
//     inst_sram_en    IF -> SRAM     read enable
//     inst_sram_we    IF -> SRAM     byte write enables (always zero)
//     inst_sram_addr  IF -> SRAM     fetch address
//     inst_sram_wdata IF -> SRAM     write data (always zero)
//     inst_sram_rdata SRAM -> IF     read data, one cycle after en
//
//   Modports
//     master  the fetch stage itself
//     slave   the environment (decode stage plus instruction SRAM)
// ---------------------------------------------------------------------------
interface if_stage_if;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  br_taken,
    input  br_target,
    input  ds_allowin,
    input  inst_sram_rdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output inst_sram_en,
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata
  );

  modport slave (
    output br_taken,
    output br_target,
    output ds_allowin,
    output inst_sram_rdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  inst_sram_en,
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage of the pipelined LoongArch CPU. Owns the PC,
//   issues reads to the synchronous instruction SRAM one cycle ahead (pre-IF)
//   and presents {adef, pc, inst} to decode under a valid/allowin handshake.
//   A one-cycle branch redirect from decode squashes the instruction sitting
//   in IF, and a one-entry buffer keeps the fetched instruction stable while
//   decode stalls.
//
//   Parameters
//     RESET_PC   address of the first instruction fetched after reset
//
//   Ports
//     clk        clock
//     resetn     asynchronous active-low reset
//     fs         if_stage_if.master (decode handshake + instruction SRAM)
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic       clk,
  input  logic       resetn,
  if_stage_if.master fs
);

  logic        fs_valid_q;
  logic        fs_valid_d;
  logic [31:0] fs_pc_q;
  logic [31:0] fs_pc_d;
  logic        inst_buf_valid_q;
  logic        inst_buf_valid_d;
  logic [31:0] inst_buf_q;
  logic [31:0] inst_buf_d;

  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic        fs_adef;

  assign fs_ready_go = 1'b1;
  assign fs_allowin  = !fs_valid_q || (fs_ready_go && fs.ds_allowin);

  // Sequential PC wraps silently at 2^32; a redirect always wins over it.
  assign seq_pc = fs_pc_q + 32'd4;
  assign nextpc = fs.br_taken ? fs.br_target : seq_pc;

  // Pre-IF: a request goes out only when IF can take the result next cycle.
  // Gating with resetn keeps the SRAM quiet while the core is held in reset.
  assign fs.inst_sram_en    = resetn & fs_allowin;
  assign fs.inst_sram_addr  = nextpc;
  assign fs.inst_sram_we    = 4'b0000;
  assign fs.inst_sram_wdata = 32'h0000_0000;

  // During a stall the SRAM is not re-read, so its output may drift; the
  // buffered copy is used whenever it is populated.
  assign fs_inst = inst_buf_valid_q ? inst_buf_q : fs.inst_sram_rdata;
  assign fs_adef = (fs_pc_q[1:0] != 2'b00);

  // The instruction in IF is wrong-path in the cycle decode redirects.
  assign fs.fs_to_ds_valid = fs_valid_q & fs_ready_go & ~fs.br_taken;
  assign fs.fs_to_ds_bus   = {fs_adef, fs_pc_q, fs_inst};

  // Next-state logic: PC/valid advance whenever IF accepts a new fetch. The
  // buffer captures the SRAM data on the first stalled cycle (the only cycle
  // the SRAM output is guaranteed to belong to fs_pc) and empties as soon as
  // IF moves on or is redirected.
  always_comb begin
    fs_valid_d       = fs_valid_q;
    fs_pc_d          = fs_pc_q;
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;

    if (fs_allowin) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end

    if (fs_allowin || fs.br_taken) begin
      inst_buf_valid_d = 1'b0;
    end else if (fs_valid_q && !fs.ds_allowin && !inst_buf_valid_q) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = fs.inst_sram_rdata;
    end
  end

  // State registers. RESET_PC-4 makes the first sequential fetch land on
  // RESET_PC without a special case in the PC mux.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fs_valid_q       <= 1'b0;
      fs_pc_q          <= RESET_PC - 32'd4;
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'h0000_0000;
    end else begin
      fs_valid_q       <= fs_valid_d;
      fs_pc_q          <= fs_pc_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//   Self-checking bench for if_stage. A behavioural SRAM answers reads one
//   cycle later with a data pattern derived from the address and returns
//   random garbage whenever it is not enabled. Directed scenarios cover reset,
//   startup latency, stalls, redirects, misaligned targets and reset during a
//   stall; a random run checks the delivered instruction stream against a
//   program-order model.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  int          total = 0;
  int          bad = 0;
  logic [31:0] dataMask = 32'h0000_0000;

  if_stage_if ifBus ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .fs     (ifBus.master)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Instruction SRAM model: registered read when enabled, garbage otherwise,
  // so any reliance on the SRAM holding its output during a stall shows up.
  always @(posedge clk) begin
    if (ifBus.inst_sram_en === 1'b1)
      ifBus.inst_sram_rdata <= ifBus.inst_sram_addr ^ dataMask;
    else
      ifBus.inst_sram_rdata <= $urandom;
  end

  // Decode must never redirect while refusing an instruction.
  always @(posedge clk) begin
    if (resetn === 1'b1 && ifBus.br_taken === 1'b1 && ifBus.ds_allowin !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL illegal_branch br_taken=1 with ds_allowin=%b, required ds_allowin=1", ifBus.ds_allowin);
    end
  end

  // Expected bus contents for an instruction at a given PC.
  function automatic logic [64:0] expBus(input logic [31:0] pc);
    logic [31:0] inst;
    inst = pc ^ dataMask;
    return {(pc[1:0] != 2'b00), pc, inst};
  endfunction

  // One cycle of decode-side stimulus, then settle before sampling.
  task automatic applyStimulus(input logic allow, input logic br, input logic [31:0] tgt);
    @(negedge clk);
    ifBus.ds_allowin = allow;
    ifBus.br_taken   = br;
    ifBus.br_target  = tgt;
    #1;
  endtask

  task automatic startReset();
    resetn           = 1'b0;
    ifBus.ds_allowin = 1'b1;
    ifBus.br_taken   = 1'b0;
    ifBus.br_target  = 32'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    resetn           = 1'b1;
    ifBus.ds_allowin = 1'b1;
    ifBus.br_taken   = 1'b0;
    ifBus.br_target  = 32'h0;
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    startReset();
    #1;
    total++;
    if (ifBus.fs_to_ds_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_valid got=%b want=0", ifBus.fs_to_ds_valid);
    end
    total++;
    if (ifBus.inst_sram_en !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_sram_en got=%b want=0", ifBus.inst_sram_en);
    end
    total++;
    if ({ifBus.inst_sram_we, ifBus.inst_sram_wdata} !== 36'h0) begin
      bad++; $display("[TB] FAIL sram_write_const got=%h want=0", {ifBus.inst_sram_we, ifBus.inst_sram_wdata});
    end
  endtask

  task automatic test_reset_release();
    $display("[TB] test_reset_release");
    dataMask = 32'h0000_0000;
    startReset();
    releaseReset();
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.inst_sram_en, ifBus.inst_sram_addr} !== {1'b0, 1'b1, RESET_PC}) begin
      bad++; $display("[TB] FAIL startup_request got=%h want=%h",
                      {ifBus.fs_to_ds_valid, ifBus.inst_sram_en, ifBus.inst_sram_addr}, {1'b0, 1'b1, RESET_PC});
    end
    for (int k = 0; k < 6; k++) begin
      logic [31:0] pc;
      pc = RESET_PC + 32'(4 * k);
      applyStimulus(1'b1, 1'b0, 32'h0);
      total++;
      if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, expBus(pc)}) begin
        bad++; $display("[TB] FAIL seq_bus[%0d] got=%h want=%h", k, {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, expBus(pc)});
      end
      total++;
      if ({ifBus.inst_sram_en, ifBus.inst_sram_addr} !== {1'b1, pc + 32'd4}) begin
        bad++; $display("[TB] FAIL seq_req[%0d] got=%h want=%h", k, {ifBus.inst_sram_en, ifBus.inst_sram_addr}, {1'b1, pc + 32'd4});
      end
    end
  endtask

  task automatic test_stall();
    $display("[TB] test_stall");
    dataMask = 32'h5a5a_0000;
    startReset();
    releaseReset();
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      total++;
      if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, expBus(32'h1c000008)}) begin
        bad++; $display("[TB] FAIL stall_bus[%0d] got=%h want=%h", s, {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, expBus(32'h1c000008)});
      end
      total++;
      if (ifBus.inst_sram_en !== 1'b0) begin
        bad++; $display("[TB] FAIL stall_sram_en[%0d] got=%b want=0", s, ifBus.inst_sram_en);
      end
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_bus, ifBus.inst_sram_en, ifBus.inst_sram_addr} !== {expBus(32'h1c000008), 1'b1, 32'h1c00000c}) begin
      bad++; $display("[TB] FAIL stall_release got=%h want=%h",
                      {ifBus.fs_to_ds_bus, ifBus.inst_sram_en, ifBus.inst_sram_addr}, {expBus(32'h1c000008), 1'b1, 32'h1c00000c});
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, expBus(32'h1c00000c)}) begin
      bad++; $display("[TB] FAIL stall_resume got=%h want=%h", {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, expBus(32'h1c00000c)});
    end
  endtask

  task automatic test_redirect();
    $display("[TB] test_redirect");
    dataMask = 32'h0f0f_1234;
    startReset();
    releaseReset();
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h1c000100);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.inst_sram_en, ifBus.inst_sram_addr} !== {1'b0, 1'b1, 32'h1c000100}) begin
      bad++; $display("[TB] FAIL redirect_squash got=%h want=%h",
                      {ifBus.fs_to_ds_valid, ifBus.inst_sram_en, ifBus.inst_sram_addr}, {1'b0, 1'b1, 32'h1c000100});
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, expBus(32'h1c000100)}) begin
      bad++; $display("[TB] FAIL redirect_target got=%h want=%h", {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, expBus(32'h1c000100)});
    end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    dataMask = 32'h3c3c_0000;
    startReset();
    releaseReset();
    repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h1c000200);
    total++;
    if (ifBus.fs_to_ds_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_first_squash got=%b want=0", ifBus.fs_to_ds_valid);
    end
    applyStimulus(1'b1, 1'b1, 32'h1c000300);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.inst_sram_addr} !== {1'b0, 32'h1c000300}) begin
      bad++; $display("[TB] FAIL b2b_second_squash got=%h want=%h", {ifBus.fs_to_ds_valid, ifBus.inst_sram_addr}, {1'b0, 32'h1c000300});
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, expBus(32'h1c000300)}) begin
      bad++; $display("[TB] FAIL b2b_target got=%h want=%h", {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, expBus(32'h1c000300)});
    end
  endtask

  task automatic test_branch_idle();
    $display("[TB] test_branch_idle");
    dataMask = 32'h0000_ffff;
    startReset();
    @(negedge clk);
    resetn           = 1'b1;
    ifBus.ds_allowin = 1'b1;
    ifBus.br_taken   = 1'b1;
    ifBus.br_target  = 32'h1c000400;
    #1;
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.inst_sram_en, ifBus.inst_sram_addr} !== {1'b0, 1'b1, 32'h1c000400}) begin
      bad++; $display("[TB] FAIL idle_redirect_req got=%h want=%h",
                      {ifBus.fs_to_ds_valid, ifBus.inst_sram_en, ifBus.inst_sram_addr}, {1'b0, 1'b1, 32'h1c000400});
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, expBus(32'h1c000400)}) begin
      bad++; $display("[TB] FAIL idle_redirect_bus got=%h want=%h", {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, expBus(32'h1c000400)});
    end
  endtask

  task automatic test_adef();
    $display("[TB] test_adef");
    dataMask = 32'ha5a5_5a5a;
    startReset();
    releaseReset();
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h1c000102);
    applyStimulus(1'b1, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, 1'b1, 32'h1c000102, 32'h1c000102 ^ dataMask}) begin
      bad++; $display("[TB] FAIL adef_first got=%h want=%h",
                      {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, 1'b1, 32'h1c000102, 32'h1c000102 ^ dataMask});
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, 1'b1, 32'h1c000106, 32'h1c000106 ^ dataMask}) begin
      bad++; $display("[TB] FAIL adef_next got=%h want=%h",
                      {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, 1'b1, 32'h1c000106, 32'h1c000106 ^ dataMask});
    end
    // PC arithmetic wraps at the top of the address space.
    applyStimulus(1'b1, 1'b1, 32'hfffffffc);
    applyStimulus(1'b1, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_bus, ifBus.inst_sram_addr} !== {expBus(32'hfffffffc), 32'h0000_0000}) begin
      bad++; $display("[TB] FAIL pc_wrap got=%h want=%h", {ifBus.fs_to_ds_bus, ifBus.inst_sram_addr}, {expBus(32'hfffffffc), 32'h0000_0000});
    end
  endtask

  task automatic test_reset_mid_stall();
    $display("[TB] test_reset_mid_stall");
    dataMask = 32'h1111_2222;
    startReset();
    releaseReset();
    repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, expBus(32'h1c000008)}) begin
      bad++; $display("[TB] FAIL pre_reset_stall got=%h want=%h", {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, expBus(32'h1c000008)});
    end
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.inst_sram_en} !== 2'b00) begin
      bad++; $display("[TB] FAIL async_reset got=%b want=00", {ifBus.fs_to_ds_valid, ifBus.inst_sram_en});
    end
    releaseReset();
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.inst_sram_addr} !== {1'b0, RESET_PC}) begin
      bad++; $display("[TB] FAIL restart_req got=%h want=%h", {ifBus.fs_to_ds_valid, ifBus.inst_sram_addr}, {1'b0, RESET_PC});
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    total++;
    if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, expBus(RESET_PC)}) begin
      bad++; $display("[TB] FAIL restart_bus got=%h want=%h", {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, expBus(RESET_PC)});
    end
  endtask

  // Random traffic checked against a program-order model: expPc is the PC of
  // the next instruction decode should receive. A redirect replaces it, an
  // accepted transfer advances it by 4, and a stall leaves it alone.
  task automatic test_random();
    logic [31:0] expPc;
    logic        allow;
    logic        br;
    logic [31:0] tgt;
    $display("[TB] test_random");
    dataMask = $urandom;
    startReset();
    releaseReset();
    expPc = RESET_PC;
    for (int n = 0; n < 500; n++) begin
      allow = ($urandom_range(0, 3) != 0);
      br    = allow && ($urandom_range(0, 7) == 0);
      tgt   = RESET_PC + {20'h0, 10'($urandom_range(0, 1023)), 2'b00}
              + (($urandom_range(0, 5) == 0) ? 32'd2 : 32'd0);
      applyStimulus(allow, br, tgt);
      if (br) begin
        total++;
        if ({ifBus.fs_to_ds_valid, ifBus.inst_sram_en, ifBus.inst_sram_addr} !== {1'b0, 1'b1, tgt}) begin
          bad++; $display("[TB] FAIL rand_branch[%0d] got=%h want=%h", n,
                          {ifBus.fs_to_ds_valid, ifBus.inst_sram_en, ifBus.inst_sram_addr}, {1'b0, 1'b1, tgt});
        end
        expPc = tgt;
      end else begin
        total++;
        if ({ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus} !== {1'b1, expBus(expPc)}) begin
          bad++; $display("[TB] FAIL rand_bus[%0d] got=%h want=%h", n, {ifBus.fs_to_ds_valid, ifBus.fs_to_ds_bus}, {1'b1, expBus(expPc)});
        end
        total++;
        if (ifBus.inst_sram_en !== allow) begin
          bad++; $display("[TB] FAIL rand_sram_en[%0d] got=%b want=%b", n, ifBus.inst_sram_en, allow);
        end
        if (allow) begin
          total++;
          if (ifBus.inst_sram_addr !== expPc + 32'd4) begin
            bad++; $display("[TB] FAIL rand_addr[%0d] got=%h want=%h", n, ifBus.inst_sram_addr, expPc + 32'd4);
          end
          expPc = expPc + 32'd4;
        end
      end
    end
  endtask

  // Scenario sequencer.
  initial begin
    resetn                = 1'b0;
    ifBus.ds_allowin      = 1'b1;
    ifBus.br_taken        = 1'b0;
    ifBus.br_target       = 32'h0;
    test_reset();
    test_reset_release();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_branch_idle();
    test_adef();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
